// File: rtl/instruction_memory_pkg.sv
// Shared Y86 constants for instruction memory and fetch: capacity, fetch window, halt opcode.
// Pure declarations; no latency or flow control involved.
package instruction_memory_pkg;

  localparam int          MEM_SIZE_DEFAULT = 1024;
  localparam int          ADDR_W_DEFAULT   = 10;
  localparam int          FETCH_BYTES      = 10;
  localparam logic [7:0]  HALT_OP          = 8'h00;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/instruction_memory.sv
// Byte-addressed Y86 instruction store: 10-byte fetch window, combinational read (0 cycles).
// Program-load writes take effect on the rising clk edge; no handshake or backpressure.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       PC,
  output logic [7:0]        im_out0,
  output logic [7:0]        im_out1,
  output logic [7:0]        im_out2,
  output logic [7:0]        im_out3,
  output logic [7:0]        im_out4,
  output logic [7:0]        im_out5,
  output logic [7:0]        im_out6,
  output logic [7:0]        im_out7,
  output logic [7:0]        im_out8,
  output logic [7:0]        im_out9,
  output logic              imem_error,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata
);

  // One guard bit so PC+k never wraps back into low memory.
  localparam logic [64:0] MEM_END = 65'(MEM_SIZE);

  byte_t mem [MEM_SIZE];
  byte_t lane_dat [FETCH_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= HALT_OP;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign imem_error = ({1'b0, PC} >= MEM_END);

  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_lane
    logic [64:0] addr;
    assign addr        = {1'b0, PC} + 65'(k);
    assign lane_dat[k] = (!imem_error && (addr < MEM_END)) ? mem[addr[ADDR_W-1:0]] : HALT_OP;
  end

  assign im_out0 = lane_dat[0];
  assign im_out1 = lane_dat[1];
  assign im_out2 = lane_dat[2];
  assign im_out3 = lane_dat[3];
  assign im_out4 = lane_dat[4];
  assign im_out5 = lane_dat[5];
  assign im_out6 = lane_dat[6];
  assign im_out7 = lane_dat[7];
  assign im_out8 = lane_dat[8];
  assign im_out9 = lane_dat[9];

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: reset, load/fetch, boundaries, write-while-read, async reset.
module tb_instruction_memory;

  logic        clk;
  logic        rst_n;
  logic [63:0] PC;
  logic [7:0]  im_out0, im_out1, im_out2, im_out3, im_out4;
  logic [7:0]  im_out5, im_out6, im_out7, im_out8, im_out9;
  logic        imem_error;
  logic        we;
  logic [9:0]  waddr;
  logic [7:0]  wdata;

  logic [7:0]  got [10];

  int checks = 0;
  int errors = 0;

  instruction_memory #(.MEM_SIZE(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC         (PC),
    .im_out0    (im_out0),
    .im_out1    (im_out1),
    .im_out2    (im_out2),
    .im_out3    (im_out3),
    .im_out4    (im_out4),
    .im_out5    (im_out5),
    .im_out6    (im_out6),
    .im_out7    (im_out7),
    .im_out8    (im_out8),
    .im_out9    (im_out9),
    .imem_error (imem_error),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata)
  );

  assign got[0] = im_out0;
  assign got[1] = im_out1;
  assign got[2] = im_out2;
  assign got[3] = im_out3;
  assign got[4] = im_out4;
  assign got[5] = im_out5;
  assign got[6] = im_out6;
  assign got[7] = im_out7;
  assign got[8] = im_out8;
  assign got[9] = im_out9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected window packed with byte k at bits [8k+7:8k].
  task automatic chk_win(input string tag, input logic [79:0] exp, input logic exp_err);
    chk({tag, "_err"}, 64'(imem_error), 64'(exp_err));
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_b%0d", tag, k), 64'(got[k]), 64'(exp[8*k +: 8]));
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  logic [7:0] prog [10];

  initial begin
    prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0;
    PC    = 64'd0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;

    // Write attempted during reset must be ignored.
    @(negedge clk);
    we    = 1'b1;
    waddr = 10'd0;
    wdata = 8'h55;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_win("reset", 80'h0, 1'b0);

    for (int i = 0; i < 10; i++) wr(10'(i), prog[i]);
    PC = 64'd0;
    #1;
    chk_win("load", 80'h0A_F2_30, 1'b0);
    PC = 64'd1;
    #1;
    chk_win("pc1", 80'h0A_F2, 1'b0);

    wr(10'd1023, 8'h10);
    PC = 64'd1023;
    #1;
    chk_win("pc1023", 80'h10, 1'b0);
    PC = 64'd1016;
    #1;
    chk_win("pc1016", {8'h00, 8'h00, 8'h10, 56'h0}, 1'b0);
    PC = 64'd1024;
    #1;
    chk_win("pc1024", 80'h0, 1'b1);
    PC = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk_win("pcmax", 80'h0, 1'b1);
    PC = 64'h0000_0001_0000_0000;
    #1;
    chk_win("pchigh", 80'h0, 1'b1);

    // Write-while-read: old value until the edge, new value right after.
    PC = 64'd5;
    @(negedge clk);
    we    = 1'b1;
    waddr = 10'd5;
    wdata = 8'hAB;
    #1;
    chk("wwr_before", 64'(im_out0), 64'h00);
    @(posedge clk);
    #1;
    we = 1'b0;
    chk("wwr_after", 64'(im_out0), 64'hAB);

    // we=0 edge leaves contents alone.
    @(negedge clk);
    waddr = 10'd5;
    wdata = 8'h77;
    @(posedge clk);
    #1;
    chk("we0_hold", 64'(im_out0), 64'hAB);

    // Asynchronous reset between edges clears contents at once.
    PC = 64'd0;
    #1;
    chk("pre_rst_b0", 64'(im_out0), 64'h30);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_win("async_rst", 80'h0, 1'b0);
    #1;
    rst_n = 1'b1;
    PC = 64'd1019;
    #1;
    chk_win("post_rst_end", 80'h0, 1'b0);
    PC = 64'd5;
    #1;
    chk("post_rst_b5", 64'(im_out0), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
